gppcu_fpu_arbiter: RTL and testbench

GPPCU_FPU_ARBITER -- requirements
Module: gppcu_fpu_arbiter

---
 rtl/gppcu_fpu_arbiter.sv | 173 +++++++++++++++++
 tb/tb_gppcu_fpu_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gppcu_fpu_arbiter.sv
// Round-robin arbiter between NTHREAD thread requesters and one shared multicycle FPU.
// A winner's operands and opcode are latched and the FPU is started. The result goes back to
// the winner as a one-cycle oDONE pulse. A watchdog moves the FSM to a terminal ERR state if
// the FPU never answers; only iRST leaves ERR.
//
// Ports:
//   iACLK, iRST              clock, synchronous active-high reset
//   iREQ[NTHREAD]            per-thread request, held until that thread's oDONE bit
//   iOPA/iOPB[NTHREAD*DBW]   per-thread operands (slice k = thread k)
//   iOPC[NTHREAD*3]          per-thread opcode (slice k = thread k)
//   oDONE[NTHREAD]           one-cycle completion pulse to the served thread
//   oRESULT[DBW]             result, valid only while an oDONE bit is high
//   oGRANT                   index of the thread being served
//   oBUSY, oERR              FSM not idle / sticky watchdog timeout
//   oFPU_START, oFPU_DATAA, oFPU_DATAB, oFPU_N   FPU start pulse, latched operands, opcode
//   iFPU_DONE, iFPU_RESULT   FPU completion strobe and result
module gppcu_fpu_arbiter #(
    parameter int unsigned NTHREAD = 4,
    parameter int unsigned DBW     = 32,
    parameter int unsigned TOW     = 8
) (
    input  logic                       iACLK,
    input  logic                       iRST,
    input  logic [NTHREAD-1:0]         iREQ,
    input  logic [NTHREAD*DBW-1:0]     iOPA,
    input  logic [NTHREAD*DBW-1:0]     iOPB,
    input  logic [NTHREAD*3-1:0]       iOPC,
    output logic [NTHREAD-1:0]         oDONE,
    output logic [DBW-1:0]             oRESULT,
    output logic [$clog2(NTHREAD)-1:0] oGRANT,
    output logic                       oBUSY,
    output logic                       oERR,
    output logic                       oFPU_START,
    output logic [DBW-1:0]             oFPU_DATAA,
    output logic [DBW-1:0]             oFPU_DATAB,
    output logic [2:0]                 oFPU_N,
    input  logic                       iFPU_DONE,
    input  logic [DBW-1:0]             iFPU_RESULT
);

    localparam int unsigned GW = $clog2(NTHREAD);
    // Value the watchdog holds in the last WAIT cycle before timeout (2^TOW-1 WAIT cycles).
    localparam logic [TOW-1:0] WdogLast = {{(TOW-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {StIdle, StStart, StWait, StDone, StErr} state_e;

    state_e             state_q, state_d;
    logic [GW-1:0]      ptr_q, ptr_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic [DBW-1:0]     opa_q, opa_d;
    logic [DBW-1:0]     opb_q, opb_d;
    logic [2:0]         opc_q, opc_d;
    logic [DBW-1:0]     res_q, res_d;
    logic               err_q, err_d;
    logic               err_pulsed_q, err_pulsed_d;
    logic [TOW-1:0]     wdog_q, wdog_d;
    logic               mask_q, mask_d;

    logic [NTHREAD-1:0] served;
    logic [NTHREAD-1:0] eligible;
    logic               any_req;
    logic [GW-1:0]      win;

    always_comb begin
        served          = '0;
        served[grant_q] = 1'b1;
    end

    // The just-served thread is masked for the single IDLE cycle after DONE.
    assign eligible = iREQ & ~(mask_q ? served : '0);

    // Round-robin search starting at ptr_q; index arithmetic wraps at NTHREAD (power of two).
    always_comb begin
        any_req = 1'b0;
        win     = '0;
        for (int unsigned i = 0; i < NTHREAD; i++) begin
            if (!any_req && eligible[ptr_q + GW'(i)]) begin
                any_req = 1'b1;
                win     = ptr_q + GW'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        opc_d        = opc_q;
        res_d        = res_q;
        err_d        = err_q;
        err_pulsed_d = err_pulsed_q;
        wdog_d       = wdog_q;
        mask_d       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StStart;
                    grant_d = win;
                    opa_d   = iOPA[win*DBW +: DBW];
                    opb_d   = iOPB[win*DBW +: DBW];
                    opc_d   = iOPC[win*3 +: 3];
                end
            end
            StStart: begin
                state_d = StWait;
                wdog_d  = '0;
            end
            StWait: begin
                wdog_d = wdog_q + TOW'(1);
                // A completion in the timeout cycle still wins over the watchdog.
                if (iFPU_DONE) begin
                    state_d = StDone;
                    res_d   = iFPU_RESULT;
                end else if (wdog_q == WdogLast) begin
                    state_d = StErr;
                    err_d   = 1'b1;
                    res_d   = '0;
                end
            end
            StDone: begin
                state_d = StIdle;
                ptr_d   = grant_q + GW'(1);
                mask_d  = 1'b1;
            end
            StErr: begin
                err_pulsed_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iACLK) begin
        if (iRST) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            grant_q      <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            opc_q        <= '0;
            res_q        <= '0;
            err_q        <= 1'b0;
            err_pulsed_q <= 1'b0;
            wdog_q       <= '0;
            mask_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            opc_q        <= opc_d;
            res_q        <= res_d;
            err_q        <= err_d;
            err_pulsed_q <= err_pulsed_d;
            wdog_q       <= wdog_d;
            mask_q       <= mask_d;
        end
    end

    // ERR reports the timeout to the stuck thread once, on its first cycle.
    assign oDONE      = ((state_q == StDone) || (state_q == StErr && !err_pulsed_q)) ? served : '0;
    assign oRESULT    = (state_q == StDone) ? res_q : '0;
    assign oGRANT     = grant_q;
    assign oBUSY      = (state_q != StIdle);
    assign oERR       = err_q;
    assign oFPU_START = (state_q == StStart);
    assign oFPU_DATAA = opa_q;
    assign oFPU_DATAB = opb_q;
    assign oFPU_N     = opc_q;

endmodule

// File: tb/tb_gppcu_fpu_arbiter.sv
module tb_gppcu_fpu_arbiter;

    logic        iACLK = 1'b0;
    logic        iRST;
    logic [3:0]  iREQ;
    logic [127:0] iOPA, iOPB;
    logic [11:0] iOPC;
    logic [3:0]  oDONE;
    logic [31:0] oRESULT;
    logic [1:0]  oGRANT;
    logic        oBUSY, oERR, oFPU_START;
    logic [31:0] oFPU_DATAA, oFPU_DATAB;
    logic [2:0]  oFPU_N;
    logic        iFPU_DONE;
    logic [31:0] iFPU_RESULT;

    logic [31:0] opa_t [4];
    logic [31:0] opb_t [4];
    logic [2:0]  opc_t [4];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 iACLK = ~iACLK;

    always_comb begin
        iOPA = '0;
        iOPB = '0;
        iOPC = '0;
        for (int k = 0; k < 4; k++) begin
            iOPA[k*32 +: 32] = opa_t[k];
            iOPB[k*32 +: 32] = opb_t[k];
            iOPC[k*3 +: 3]   = opc_t[k];
        end
    end

    gppcu_fpu_arbiter #(
        .NTHREAD (4),
        .DBW     (32),
        .TOW     (4)
    ) u_dut (
        .iACLK       (iACLK),
        .iRST        (iRST),
        .iREQ        (iREQ),
        .iOPA        (iOPA),
        .iOPB        (iOPB),
        .iOPC        (iOPC),
        .oDONE       (oDONE),
        .oRESULT     (oRESULT),
        .oGRANT      (oGRANT),
        .oBUSY       (oBUSY),
        .oERR        (oERR),
        .oFPU_START  (oFPU_START),
        .oFPU_DATAA  (oFPU_DATAA),
        .oFPU_DATAB  (oFPU_DATAB),
        .oFPU_N      (oFPU_N),
        .iFPU_DONE   (iFPU_DONE),
        .iFPU_RESULT (iFPU_RESULT)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge iACLK);
        #1;
    endtask

    // Step until oFPU_START, report cycles taken, and check the latched grant.
    task automatic wait_start(input int g, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 50) begin
            step();
            n++;
            if (oFPU_START) seen = 1'b1;
        end
        check("start_seen", 64'(seen), 64'd1);
        check("grant", 64'(oGRANT), 64'(g));
        check("dataa", 64'(oFPU_DATAA), 64'(opa_t[g]));
        check("datab", 64'(oFPU_DATAB), 64'(opb_t[g]));
        check("opcode", 64'(oFPU_N), 64'(opc_t[g]));
    endtask

    // From the START cycle: present iFPU_DONE lat cycles later, then check the oDONE cycle.
    task automatic finish_op(input int g, input int lat, input logic [31:0] res, input bit drop);
        repeat (lat) step();
        iFPU_DONE   = 1'b1;
        iFPU_RESULT = res;
        check("done_early", 64'(oDONE), 64'd0);
        check("busy_wait", 64'(oBUSY), 64'd1);
        step();
        iFPU_DONE   = 1'b0;
        iFPU_RESULT = 32'hDEAD_BEEF;
        check("done_bit", 64'(oDONE), 64'(4'b0001 << g));
        check("result", 64'(oRESULT), 64'(res));
        check("err_clear", 64'(oERR), 64'd0);
        if (drop) iREQ[g] = 1'b0;
    endtask

    initial begin
        int n;
        int starts;
        int dones;
        for (int k = 0; k < 4; k++) begin
            opa_t[k] = 32'hA000_0000 | k;
            opb_t[k] = 32'hB000_0000 | k;
        end
        opc_t[0] = 3'd5;
        opc_t[1] = 3'd6;
        opc_t[3] = 3'd7;
        opa_t[2] = 32'h3F80_0000;
        opb_t[2] = 32'h4000_0000;
        opc_t[2] = 3'd3;
        iRST = 1'b1;
        iREQ = '0;
        iFPU_DONE = 1'b0;
        iFPU_RESULT = 32'hDEAD_BEEF;

        // Reset state
        step();
        step();
        iRST = 1'b0;
        check("rst_busy", 64'(oBUSY), 64'd0);
        check("rst_done", 64'(oDONE), 64'd0);
        check("rst_grant", 64'(oGRANT), 64'd0);
        check("rst_start", 64'(oFPU_START), 64'd0);
        check("rst_err", 64'(oERR), 64'd0);
        check("rst_result", 64'(oRESULT), 64'd0);
        check("rst_dataa", 64'(oFPU_DATAA), 64'd0);

        // Single request from thread 2, FPU answers 5 cycles after start
        iREQ = 4'b0100;
        wait_start(2, n);
        check("t1_start_lat", 64'(n), 64'd1);
        step();
        check("t1_start_pulse", 64'(oFPU_START), 64'd0);
        finish_op(2, 4, 32'h4040_0000, 1'b1);
        step();
        check("t1_idle", 64'(oBUSY), 64'd0);

        // PTR is now 3: thread 3 wins over thread 0, then thread 0 back-to-back
        iREQ = 4'b1001;
        wait_start(3, n);
        finish_op(3, 1, 32'h1111_0003, 1'b1);
        wait_start(0, n);
        check("t2_b2b", 64'(n), 64'd2);
        finish_op(0, 2, 32'h1111_0000, 1'b1);

        // Mask: thread 1 keeps requesting after its oDONE
        step();
        iREQ = 4'b0010;
        wait_start(1, n);
        finish_op(1, 2, 32'h2222_0001, 1'b0);
        wait_start(1, n);
        check("t3_mask_gap", 64'(n), 64'd3);
        finish_op(1, 1, 32'h2222_0002, 1'b1);

        // iFPU_DONE during START is ignored; iFPU_DONE in the timeout cycle wins
        step();
        iREQ = 4'b0100;
        wait_start(2, n);
        iFPU_DONE = 1'b1;
        iFPU_RESULT = 32'h0BAD_0BAD;
        step();
        iFPU_DONE = 1'b0;
        check("t4_start_done_ign", 64'(oDONE), 64'd0);
        check("t4_still_busy", 64'(oBUSY), 64'd1);
        finish_op(2, 14, 32'h3333_0002, 1'b1);

        // Reset three cycles into WAIT (PTR is 3, so thread 2 wins)
        step();
        iREQ = 4'b0100;
        wait_start(2, n);
        repeat (3) step();
        iREQ = '0;
        iRST = 1'b1;
        step();
        iRST = 1'b0;
        check("t5_busy", 64'(oBUSY), 64'd0);
        check("t5_grant", 64'(oGRANT), 64'd0);
        check("t5_dataa", 64'(oFPU_DATAA), 64'd0);
        check("t5_datab", 64'(oFPU_DATAB), 64'd0);
        check("t5_opcode", 64'(oFPU_N), 64'd0);
        check("t5_done", 64'(oDONE), 64'd0);
        check("t5_start", 64'(oFPU_START), 64'd0);
        iFPU_DONE = 1'b1;
        step();
        iFPU_DONE = 1'b0;
        check("t5_stale_done", 64'(oDONE), 64'd0);
        check("t5_stale_busy", 64'(oBUSY), 64'd0);

        // Fairness from PTR=0 after reset
        iREQ = 4'b1111;
        wait_start(0, n);
        finish_op(0, 1, 32'h4444_0000, 1'b1);
        for (int g = 1; g < 4; g++) begin
            wait_start(g, n);
            check("t6_b2b", 64'(n), 64'd2);
            finish_op(g, g + 1, 32'h4444_0000 | g, 1'b1);
        end

        // Watchdog timeout: 15 WAIT cycles, then ERR
        step();
        iREQ = 4'b0010;
        wait_start(1, n);
        repeat (15) step();
        check("t7_pre_err", 64'(oERR), 64'd0);
        check("t7_pre_done", 64'(oDONE), 64'd0);
        step();
        check("t7_err", 64'(oERR), 64'd1);
        check("t7_err_done", 64'(oDONE), 64'b0010);
        check("t7_err_result", 64'(oRESULT), 64'd0);
        check("t7_err_busy", 64'(oBUSY), 64'd1);
        iREQ = 4'b1111;
        starts = 0;
        dones = 0;
        repeat (10) begin
            step();
            if (oFPU_START) starts++;
            if (oDONE != 0) dones++;
        end
        check("t7_no_start", 64'(starts), 64'd0);
        check("t7_single_done", 64'(dones), 64'd0);
        check("t7_sticky", 64'(oERR), 64'd1);
        iREQ = '0;
        iRST = 1'b1;
        step();
        iRST = 1'b0;
        check("t7_rst_err", 64'(oERR), 64'd0);
        check("t7_rst_busy", 64'(oBUSY), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
